// File: rtl/fir_pkg.sv
// Shared definitions for the FIR datapath and its coefficient loader.
//   COEF_W / SAMPLE_W : coefficient and sample widths (Q1.15)
//   coef_t            : signed coefficient type
//   loader_state_t    : coefficient loader FSM states
package fir_pkg;
  localparam int COEF_W   = 16;
  localparam int SAMPLE_W = 16;

  typedef logic signed [COEF_W-1:0] coef_t;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    PENDING = 2'd1,
    DRAIN   = 2'd2
  } loader_state_t;
endpackage

// File: rtl/fir_coef_bank.sv
// Shadow and active coefficient register arrays.
//   clk, rst  : clock, synchronous active-high reset (clears both banks)
//   wr_en     : write wr_data into shadow[wr_idx]
//   wr_idx    : shadow write index
//   wr_data   : coefficient to write
//   swap      : copy the whole shadow bank into the active bank
//   active    : active bank, drives the filter
module fir_coef_bank
  import fir_pkg::*;
#(
  parameter int TAPS  = 401,
  parameter int IDX_W = $clog2(TAPS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  coef_t            wr_data,
  input  logic             swap,
  output coef_t            active [0:TAPS-1]
);

  coef_t shadow_q [0:TAPS-1];
  coef_t shadow_d [0:TAPS-1];
  coef_t active_q [0:TAPS-1];
  coef_t active_d [0:TAPS-1];

  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (wr_en) shadow_d[wr_idx] = wr_data;
    // Swap takes the shadow contents as they stand before this cycle's edge.
    if (swap) active_d = shadow_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '{default: '0};
      active_q <= '{default: '0};
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
    end
  end

  assign active = active_q;

endmodule

// File: rtl/fir_coef_loader.sv
// Loads FIR coefficient sets over a valid/ready stream into a shadow bank
// and swaps them into the active bank on a sample boundary.
//   clk, rst      : clock, synchronous active-high reset
//   coef_valid    : beat valid          coef_ready : beat accepted when valid
//   coef_data     : Q1.15 coefficient   coef_last  : final beat of a set
//   sample_strobe : FIR accepts a sample this cycle; swaps happen only here
//   weights       : active bank         pending    : full set awaiting swap
//   swap_done     : pulse, active bank updated this cycle
//   len_err       : pulse, last set had wrong length and was dropped
//
// state   | meaning
// LOAD    | accepting beats into shadow[idx]
// PENDING | full set in shadow, waiting for sample_strobe to swap
// DRAIN   | over-length set, discarding beats up to coef_last
module fir_coef_loader
  import fir_pkg::*;
#(
  parameter int TAPS = 401
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  coef_valid,
  output logic  coef_ready,
  input  coef_t coef_data,
  input  logic  coef_last,
  input  logic  sample_strobe,
  output coef_t weights [0:TAPS-1],
  output logic  pending,
  output logic  swap_done,
  output logic  len_err
);

  localparam int IDX_W = $clog2(TAPS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(TAPS - 1);

  loader_state_t    state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             coef_ready_q, coef_ready_d;
  logic             swap_done_q, swap_done_d;
  logic             len_err_q, len_err_d;
  logic             wr_en, swap, beat;

  assign beat = coef_valid && coef_ready_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    wr_en       = 1'b0;
    swap        = 1'b0;
    swap_done_d = 1'b0;
    len_err_d   = 1'b0;
    case (state_q)
      LOAD: begin
        if (beat) begin
          wr_en = 1'b1;
          if (idx_q == IDX_LAST) begin
            idx_d = '0;
            if (coef_last) begin
              state_d = PENDING;
            end else begin
              len_err_d = 1'b1;
              state_d   = DRAIN;
            end
          end else if (coef_last) begin
            len_err_d = 1'b1;
            idx_d     = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      PENDING: begin
        if (sample_strobe) begin
          swap        = 1'b1;
          swap_done_d = 1'b1;
          state_d     = LOAD;
          idx_d       = '0;
        end
      end
      DRAIN: begin
        if (beat && coef_last) begin
          state_d = LOAD;
          idx_d   = '0;
        end
      end
      default: begin
        state_d = LOAD;
        idx_d   = '0;
      end
    endcase
    // Ready follows the next state so it is a clean flop output.
    coef_ready_d = (state_d != PENDING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= LOAD;
      idx_q        <= '0;
      coef_ready_q <= 1'b1;
      swap_done_q  <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      coef_ready_q <= coef_ready_d;
      swap_done_q  <= swap_done_d;
      len_err_q    <= len_err_d;
    end
  end

  fir_coef_bank #(
    .TAPS  (TAPS),
    .IDX_W (IDX_W)
  ) u_bank (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (idx_q),
    .wr_data (coef_data),
    .swap    (swap),
    .active  (weights)
  );

  assign coef_ready = coef_ready_q;
  assign pending    = (state_q == PENDING);
  assign swap_done  = swap_done_q;
  assign len_err    = len_err_q;

endmodule

// File: doc/fir_coef_loader.md
# fir_coef_loader

Loads a new set of FIR coefficients over a serial valid/ready stream while the filter keeps running on the old set. It sits directly upstream of the `fir` block and drives its `in_weights` array. Coefficients are written into a shadow bank, then copied into the active bank on a sample boundary, so the filter never computes a sample with a mixed set.

## Interface
Parameters:
- `TAPS`, 401: number of coefficients per set; must be ≥ 2.

Ports:
- `clk`  in  1  single clock for the block.
- `rst`  in  1  synchronous, active-high reset.
- `coef_valid`  in  1  `coef_data` and `coef_last` are valid this cycle.
- `coef_ready`  out  1  block accepts a beat this cycle.
- `coef_data`  in  16  signed Q1.15 coefficient.
- `coef_last`  in  1  marks the final beat of a set.
- `sample_strobe`  in  1  high in the cycle the FIR accepts a new sample; a bank swap happens only in such a cycle.
- `weights`  out  16 × [0:TAPS-1]  active bank; connects to `fir.in_weights`.
- `pending`  out  1  a complete set is waiting in the shadow bank.
- `swap_done`  out  1  one-cycle pulse; the active bank was updated this cycle.
- `len_err`  out  1  one-cycle pulse; the set just received had the wrong length and was discarded.

## Operation
- A beat is accepted when `coef_valid && coef_ready`.
- Beat order: the first beat goes to index 0, which is the coefficient for the newest sample.
- Index counter `idx` is `$clog2(TAPS)` bits wide and counts 0..TAPS-1.
- The state machine has three states: LOAD, PENDING and DRAIN.
- **LOAD** (`coef_ready`=1):
  - Each accepted beat writes `shadow[idx]` and increments `idx`.
  - Accepted beat with `coef_last`=1 and `idx`==TAPS-1: go to PENDING.
  - Accepted beat with `coef_last`=1 and `idx`<TAPS-1: the set is too short. Pulse `len_err`, set `idx`=0, stay in LOAD. The partial shadow contents are don't-care.
  - Accepted beat with `coef_last`=0 and `idx`==TAPS-1: the set is too long. Pulse `len_err` and go to DRAIN.
- **PENDING** (`coef_ready`=0, `pending`=1):
  - In the first cycle with `sample_strobe`=1, copy the whole shadow bank into the active bank.
  - In that same cycle, go to LOAD with `idx`=0.
  - The register outputs `swap_done`=1 and the new `weights` values are both visible in the following cycle.
- **DRAIN** (`coef_ready`=1): discard accepted beats. When a beat with `coef_last`=1 is accepted, go to LOAD with `idx`=0.
- The active bank changes only on a swap. Shadow writes never affect `weights`.
- No arithmetic is done on the data. Coefficients pass through bit-exact.

## Timing
- Reset values:
  - state = LOAD, `idx`=0.
  - `weights` all 0, so the FIR outputs 0 until the first swap.
  - `shadow` all 0, `coef_ready`=1, `pending`=0, `swap_done`=0, `len_err`=0.
- `coef_ready` is a registered function of the state. It does not depend on `coef_valid`.
- Last beat accepted in cycle N:
  - `pending`=1 and `coef_ready`=0 from cycle N+1.
  - The earliest swap is in cycle S ≥ N+1 with `sample_strobe`=1.
  - The new `weights` values and `swap_done` appear in cycle S+1.
  - `coef_ready` returns to 1 in cycle S+1.
- If `sample_strobe` is high in cycle N, it does not cause a swap; it is too early.
- `len_err` is asserted in the cycle after the offending beat, for exactly 1 cycle.
- Throughput: 1 beat/cycle in LOAD. A full set takes a minimum of TAPS + 1 cycles before it is eligible to swap.
- `rst` asserted mid-load or while pending:
  - Everything returns to reset values, including `weights`.
  - A pending set is lost.

## Structure
- Package `fir_pkg` holds:
  - `COEF_W`=16 and `SAMPLE_W`=16, shared with `fir`.
  - `typedef logic signed [COEF_W-1:0] coef_t`.
  - The enum `loader_state_t` {LOAD, PENDING, DRAIN}.
- Sub-module `fir_coef_bank` holds the shadow and active register arrays.
  - Inputs: write-enable, write-index, write-data and swap.
  - Output: the active array.
- The FSM and index counter stay in `fir_coef_loader`.

## Test plan
Run with TAPS=4 unless stated otherwise.
- **Reset:** assert `rst` for 2 cycles → `weights`={0,0,0,0}, `coef_ready`=1, `pending`=0.
- **Normal load:**
  - Stimulus: send 0x1000, 0x2000, 0xE000, 0x7FFF with `coef_last` on beat 4, and hold `sample_strobe`=0 for 5 cycles.
  - Response: `pending`=1, `coef_ready`=0, and `weights` stays all 0.
  - Then pulse `sample_strobe` once → one cycle later `weights`={0x1000,0x2000,0xE000,0x7FFF} and `swap_done`=1 for exactly 1 cycle.
- **Short set:** send 2 beats with `coef_last` on beat 2 → `len_err` pulses once. A following correct 4-beat set loads and swaps normally. `weights` is unchanged before that swap.
- **Long set:** send 6 beats with `coef_last` on beat 6 → `len_err` pulses after beat 4, beats 5–6 are dropped, and there is no `pending`. The next 4-beat set loads correctly.
- **Backpressure and strobe timing:**
  - Toggle `coef_valid` randomly during a load → the beat count is honoured.
  - Hold `sample_strobe`=1 continuously → the swap occurs exactly one cycle after `pending` rises.
- **Reset mid-operation and full size:**
  - Assert `rst` while `pending`=1 → `weights` returns to 0 and no swap occurs.
  - With TAPS=401, a ramp load (coefficient k = k) → `weights[k]`=k for all k after the swap.
